// File: rtl/report_collector.sv
// Report collector: tags report-STE activations with the offset of the symbol that
// caused them and queues {offset, vector} events in a FIFO drained over valid/ready.
module report_collector #(
    parameter int NUM_REPORTS = 1,
    parameter int OFFSET_W    = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DROP_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          stream_start,
    input  logic [NUM_REPORTS-1:0]        report_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OFFSET_W-1:0]           out_offset,
    output logic [NUM_REPORTS-1:0]        out_vector,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [DROP_W-1:0]             drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [OFFSET_W-1:0]    offset;
        logic [NUM_REPORTS-1:0] vector;
    } entry_t;

    logic [OFFSET_W-1:0] sym_cnt;
    logic [OFFSET_W-1:0] off_q;
    logic                run_q;

    entry_t              mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                wr_en;
    logic                drop;
    entry_t              head;

    // Symbol offset tracking; off_q lines up with report_in, which lags run by one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt <= '0;
            off_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= run;
            if (stream_start) begin
                sym_cnt <= run ? OFFSET_W'(1) : '0;
                if (run)
                    off_q <= '0;
            end else if (run) begin
                sym_cnt <= sym_cnt + OFFSET_W'(1);
                off_q   <= sym_cnt;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = run_q & (|report_in);
    assign pop   = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= '{offset: off_q, vector: report_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Clear and drop in the same cycle leaves exactly that one drop recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (overflow_clr) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_count))
                drop_count <= drop_count + DROP_W'(1);
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign out_valid  = ~empty;
    assign out_offset = empty ? '0 : head.offset;
    assign out_vector = empty ? '0 : head.vector;
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_report_collector.sv
// Directed bench for report_collector (4-bit offsets, 2 report bits, 16-deep FIFO,
// 3-bit drop counter so saturation is reachable).
module tb_report_collector;

    localparam int NR = 2;
    localparam int OW = 4;
    localparam int FD = 16;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic          stream_start;
    logic [NR-1:0] report_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_offset;
    logic [NR-1:0] out_vector;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          overflow_clr;
    logic [DW-1:0] drop_count;

    int passed = 0;
    int total  = 0;

    report_collector #(.NUM_REPORTS(NR), .OFFSET_W(OW), .FIFO_DEPTH(FD), .DROP_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .stream_start(stream_start),
        .report_in(report_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_offset(out_offset), .out_vector(out_vector), .fifo_level(fifo_level),
        .overflow(overflow), .overflow_clr(overflow_clr), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // New stream, then n symbols; symbol k raises report_in (one cycle later) if mask[k].
    task automatic feed(input int n, input logic [31:0] mask, input logic [NR-1:0] vec);
        stream_start = 1'b1; run = 1'b0; report_in = '0;
        tick();
        stream_start = 1'b0;
        for (int j = 0; j <= n; j++) begin
            run       = (j < n);
            report_in = (j > 0 && mask[j-1]) ? vec : '0;
            tick();
        end
        run = 1'b0; report_in = '0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", out_valid); else passed++;
        total++; if (fifo_level !== 5'd0) $display("FAIL rst_level: got %0d exp 0", fifo_level); else passed++;
        total++; if (overflow !== 1'b0 || drop_count !== 3'd0) $display("FAIL rst_ovf: got %0b/%0d exp 0/0", overflow, drop_count); else passed++;
        total++; if (out_offset !== 4'd0 || out_vector !== 2'd0) $display("FAIL rst_head: got %0d/%0d exp 0/0", out_offset, out_vector); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_event();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run       = 1'b1;
            report_in = (k == 4) ? 2'b01 : 2'b00;
            tick();
            if (k == 3) begin
                total++; if (out_valid !== 1'b0) $display("FAIL t1_early_valid: got %0b exp 0", out_valid); else passed++;
            end
        end
        total++; if (out_valid !== 1'b1) $display("FAIL t1_latency: got %0b exp 1", out_valid); else passed++;
        total++; if (out_offset !== 4'd3 || out_vector !== 2'b01) $display("FAIL t1_entry: got %0d/%0b exp 3/01", out_offset, out_vector); else passed++;
        run = 1'b0; report_in = '0;
        tick();
        // report_in without a preceding run must be ignored
        report_in = 2'b11;
        tick(); tick();
        report_in = '0;
        total++; if (fifo_level !== 5'd1) $display("FAIL t1_one_event: got %0d exp 1", fifo_level); else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL t1_drained: got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        feed(8, 32'h55, 2'b10);
        total++; if (fifo_level !== 5'd4) $display("FAIL t2_level: got %0d exp 4", fifo_level); else passed++;
        for (int s = 0; s < 3; s++) begin
            total++; if (out_offset !== 4'd0 || out_vector !== 2'b10) $display("FAIL t2_stall: got %0d/%0b exp 0/10", out_offset, out_vector); else passed++;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_offset !== 4'(2*i)) $display("FAIL t2_order: got %0d exp %0d", out_offset, 2*i); else passed++;
            tick();
            total++; if (fifo_level !== 5'(3-i)) $display("FAIL t2_level_dec: got %0d exp %0d", fifo_level, 3-i); else passed++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        feed(20, 32'hFFFFF, 2'b01);
        total++; if (fifo_level !== 5'd16) $display("FAIL t3_level: got %0d exp 16", fifo_level); else passed++;
        total++; if (overflow !== 1'b1 || drop_count !== 3'd4) $display("FAIL t3_drop: got %0b/%0d exp 1/4", overflow, drop_count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (out_offset !== 4'(i)) $display("FAIL t3_offset: got %0d exp %0d", out_offset, i); else passed++;
            tick();
        end
        out_ready = 1'b0;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0 || drop_count !== 3'd0) $display("FAIL t3_clr: got %0b/%0d exp 0/0", overflow, drop_count); else passed++;
        // 26 events into an empty FIFO: 10 drops, counter saturates at 7
        feed(26, 32'h3FFFFFF, 2'b01);
        total++; if (drop_count !== 3'd7) $display("FAIL t3_saturate: got %0d exp 7", drop_count); else passed++;
        run = 1'b1;
        tick();
        run = 1'b0; report_in = 2'b01; overflow_clr = 1'b1;
        tick();
        report_in = '0; overflow_clr = 1'b0;
        total++; if (overflow !== 1'b1 || drop_count !== 3'd1) $display("FAIL t3_clr_drop: got %0b/%0d exp 1/1", overflow, drop_count); else passed++;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0 || drop_count !== 3'd0) $display("FAIL t3_clr2: got %0b/%0d exp 0/0", overflow, drop_count); else passed++;
        out_ready = 1'b1;
        repeat (16) tick();
        out_ready = 1'b0;
        total++; if (fifo_level !== 5'd0) $display("FAIL t3_empty: got %0d exp 0", fifo_level); else passed++;
    endtask

    task automatic test_full_push_pop();
        feed(16, 32'hFFFF, 2'b10);
        total++; if (fifo_level !== 5'd16 || overflow !== 1'b0) $display("FAIL t4_full: got %0d/%0b exp 16/0", fifo_level, overflow); else passed++;
        run = 1'b1;
        tick();
        run = 1'b0; report_in = 2'b01; out_ready = 1'b1;
        tick();
        report_in = '0; out_ready = 1'b0;
        total++; if (fifo_level !== 5'd16) $display("FAIL t4_level: got %0d exp 16", fifo_level); else passed++;
        total++; if (overflow !== 1'b0 || drop_count !== 3'd0) $display("FAIL t4_nodrop: got %0b/%0d exp 0/0", overflow, drop_count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i < 15 && (out_offset !== 4'(i+1) || out_vector !== 2'b10))
                $display("FAIL t4_order: got %0d/%0b exp %0d/10", out_offset, out_vector, i+1);
            else if (i == 15 && (out_offset !== 4'd0 || out_vector !== 2'b01))
                $display("FAIL t4_last: got %0d/%0b exp 0/01", out_offset, out_vector);
            else passed++;
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL t4_empty: got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_wrap_start();
        feed(18, 32'h20000, 2'b01);
        total++; if (fifo_level !== 5'd1 || out_offset !== 4'd1) $display("FAIL t5_wrap: got %0d/%0d exp 1/1", fifo_level, out_offset); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        feed(1, 32'h1, 2'b10);
        total++; if (out_offset !== 4'd0 || out_vector !== 2'b10) $display("FAIL t5_restart: got %0d/%0b exp 0/10", out_offset, out_vector); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // stream_start together with run: that symbol is offset 0, the next is 1
        stream_start = 1'b1; run = 1'b1;
        tick();
        stream_start = 1'b0; report_in = 2'b01;
        tick();
        run = 1'b0;
        tick();
        report_in = '0;
        total++; if (fifo_level !== 5'd2 || out_offset !== 4'd0) $display("FAIL t5_start_run0: got %0d/%0d exp 2/0", fifo_level, out_offset); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++; if (out_offset !== 4'd1) $display("FAIL t5_start_run1: got %0d exp 1", out_offset); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        feed(20, 32'hFFFFF, 2'b11);
        out_ready = 1'b1;
        repeat (11) tick();
        out_ready = 1'b0;
        total++; if (fifo_level !== 5'd5 || overflow !== 1'b1) $display("FAIL t6_pre: got %0d/%0b exp 5/1", fifo_level, overflow); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL t6_async_valid: got %0b exp 0", out_valid); else passed++;
        total++; if (fifo_level !== 5'd0 || overflow !== 1'b0 || drop_count !== 3'd0) $display("FAIL t6_state: got %0d/%0b/%0d exp 0/0/0", fifo_level, overflow, drop_count); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0; report_in = 2'b01;
        tick();
        report_in = '0;
        total++; if (fifo_level !== 5'd1 || out_offset !== 4'd0) $display("FAIL t6_symcnt: got %0d/%0d exp 1/0", fifo_level, out_offset); else passed++;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; stream_start = 1'b0; report_in = '0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        test_reset();
        test_single_event();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_wrap_start();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
